// File: rtl/dbg_cmd_engine_if.sv
// Handshake and bus bundle for the UART debugger command engine.
// The master view belongs to the engine: it consumes received words,
// produces the reply word and drives the memory bus and MCU pause line.
interface dbg_cmd_engine_if;
   logic        rx_ready;
   logic [31:0] rx_word;
   logic        tx_busy;
   logic        tx_start;
   logic [31:0] tx_word;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mcu_pause;

   modport master (
      input  rx_ready, rx_word, tx_busy, mem_rdata, mem_ack,
      output tx_start, tx_word, mem_rd, mem_wr, mem_addr, mem_wdata, mcu_pause
   );

   modport slave (
      output rx_ready, rx_word, tx_busy, mem_rdata, mem_ack,
      input  tx_start, tx_word, mem_rd, mem_wr, mem_addr, mem_wdata, mcu_pause
   );
endinterface

// File: rtl/dbg_cmd_engine.sv
// UART debugger command engine: parses cmd/addr/data frames from the word
// receiver, performs one memory read/write or MCU pause/resume/status, and
// hands exactly one reply word to the word transmitter. A frame whose
// arguments stall past the argument timeout is silently discarded.
module dbg_cmd_engine #(
   parameter int CLK_RATE    = -1,
   parameter int ARG_TIMEOUT = 200,
   parameter int MEM_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   dbg_cmd_engine_if.master   bus
);
   // A non-positive clock rate is an unconfigured instance; keep the timer legal.
   localparam int ARG_LIMIT = (CLK_RATE > 0) ? (CLK_RATE * ARG_TIMEOUT * 1000) : 1;
   localparam int ARG_W     = $clog2(ARG_LIMIT + 1);
   localparam int MEM_W     = $clog2(MEM_TIMEOUT + 1);

   localparam logic [ARG_W-1:0] ARG_LAST = ARG_W'(ARG_LIMIT - 1);
   localparam logic [ARG_W-1:0] ARG_MAX  = ARG_W'(ARG_LIMIT);
   localparam logic [ARG_W-1:0] ARG_ONE  = ARG_W'(1);
   localparam logic [MEM_W-1:0] MEM_LAST = MEM_W'(MEM_TIMEOUT - 1);
   localparam logic [MEM_W-1:0] MEM_MAX  = MEM_W'(MEM_TIMEOUT);
   localparam logic [MEM_W-1:0] MEM_ONE  = MEM_W'(1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_GET_ADDR = 3'd1;
   localparam logic [2:0] ST_GET_DATA = 3'd2;
   localparam logic [2:0] ST_MEM_RD   = 3'd3;
   localparam logic [2:0] ST_MEM_WR   = 3'd4;
   localparam logic [2:0] ST_SEND     = 3'd5;
   localparam logic [2:0] ST_WAIT_TX  = 3'd6;

   localparam logic [7:0] OP_RD     = 8'h01;
   localparam logic [7:0] OP_WR     = 8'h02;
   localparam logic [7:0] OP_PAUSE  = 8'h03;
   localparam logic [7:0] OP_RESUME = 8'h04;
   localparam logic [7:0] OP_STATUS = 8'h05;

   localparam logic [31:0] RPL_OK     = 32'h0000_00AA;
   localparam logic [31:0] RPL_BAD_OP = 32'hFFFF_FFFE;
   localparam logic [31:0] RPL_MEM_TO = 32'hFFFF_FFFD;

   logic [2:0]       state_r;
   logic             is_wr_r;
   logic             seen_busy_r;
   logic [ARG_W-1:0] arg_tmr_r;
   logic [MEM_W-1:0] mem_tmr_r;
   logic [31:0]      reply_r;
   logic             tx_start_r;
   logic [31:0]      tx_word_r;
   logic             mem_rd_r;
   logic             mem_wr_r;
   logic [31:0]      mem_addr_r;
   logic [31:0]      mem_wdata_r;
   logic             mcu_pause_r;

   assign bus.tx_start  = tx_start_r;
   assign bus.tx_word   = tx_word_r;
   assign bus.mem_rd    = mem_rd_r;
   assign bus.mem_wr    = mem_wr_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mcu_pause = mcu_pause_r;

   // Frame sequencer: decode, argument collection, bus access and reply handoff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         is_wr_r     <= 1'b0;
         seen_busy_r <= 1'b0;
         arg_tmr_r   <= '0;
         mem_tmr_r   <= '0;
         reply_r     <= 32'h0000_0000;
         tx_start_r  <= 1'b0;
         tx_word_r   <= 32'h0000_0000;
         mem_rd_r    <= 1'b0;
         mem_wr_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         mcu_pause_r <= 1'b0;
      end else begin
         tx_start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               arg_tmr_r   <= '0;
               mem_tmr_r   <= '0;
               seen_busy_r <= 1'b0;
               if (bus.rx_ready) begin
                  case (bus.rx_word[31:24])
                     OP_RD: begin
                        is_wr_r <= 1'b0;
                        state_r <= ST_GET_ADDR;
                     end
                     OP_WR: begin
                        is_wr_r <= 1'b1;
                        state_r <= ST_GET_ADDR;
                     end
                     OP_PAUSE: begin
                        mcu_pause_r <= 1'b1;
                        reply_r     <= RPL_OK;
                        state_r     <= ST_SEND;
                     end
                     OP_RESUME: begin
                        mcu_pause_r <= 1'b0;
                        reply_r     <= RPL_OK;
                        state_r     <= ST_SEND;
                     end
                     OP_STATUS: begin
                        reply_r <= {31'd0, mcu_pause_r};
                        state_r <= ST_SEND;
                     end
                     default: begin
                        reply_r <= RPL_BAD_OP;
                        state_r <= ST_SEND;
                     end
                  endcase
               end
            end
            ST_GET_ADDR: begin
               if (bus.rx_ready) begin
                  mem_addr_r <= bus.rx_word;
                  arg_tmr_r  <= '0;
                  mem_tmr_r  <= '0;
                  if (is_wr_r) begin
                     state_r <= ST_GET_DATA;
                  end else begin
                     mem_rd_r <= 1'b1;
                     state_r  <= ST_MEM_RD;
                  end
               end else if (arg_tmr_r >= ARG_LAST) begin
                  state_r <= ST_IDLE;
               end else if (arg_tmr_r != ARG_MAX) begin
                  arg_tmr_r <= arg_tmr_r + ARG_ONE;
               end
            end
            ST_GET_DATA: begin
               if (bus.rx_ready) begin
                  mem_wdata_r <= bus.rx_word;
                  arg_tmr_r   <= '0;
                  mem_tmr_r   <= '0;
                  mem_wr_r    <= 1'b1;
                  state_r     <= ST_MEM_WR;
               end else if (arg_tmr_r >= ARG_LAST) begin
                  state_r <= ST_IDLE;
               end else if (arg_tmr_r != ARG_MAX) begin
                  arg_tmr_r <= arg_tmr_r + ARG_ONE;
               end
            end
            ST_MEM_RD, ST_MEM_WR: begin
               if (bus.mem_ack) begin
                  mem_rd_r <= 1'b0;
                  mem_wr_r <= 1'b0;
                  reply_r  <= (state_r == ST_MEM_RD) ? bus.mem_rdata : RPL_OK;
                  state_r  <= ST_SEND;
               end else if (mem_tmr_r >= MEM_LAST) begin
                  mem_rd_r <= 1'b0;
                  mem_wr_r <= 1'b0;
                  reply_r  <= RPL_MEM_TO;
                  state_r  <= ST_SEND;
               end else if (mem_tmr_r != MEM_MAX) begin
                  mem_tmr_r <= mem_tmr_r + MEM_ONE;
               end
            end
            ST_SEND: begin
               if (!bus.tx_busy) begin
                  tx_start_r  <= 1'b1;
                  tx_word_r   <= reply_r;
                  seen_busy_r <= 1'b0;
                  state_r     <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               if (!seen_busy_r) begin
                  seen_busy_r <= bus.tx_busy;
               end else if (!bus.tx_busy) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               mem_rd_r <= 1'b0;
               mem_wr_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Directed, table-driven bench for dbg_cmd_engine: a frame table with
// hand-computed replies plus sequences for argument timeout, tx backpressure
// and asynchronous reset during a write.
module tb_dbg_cmd_engine;
   localparam int MEM_TO = 16;

   logic clk;
   logic rst;
   dbg_cmd_engine_if bus ();

   dbg_cmd_engine #(.CLK_RATE(1), .ARG_TIMEOUT(1), .MEM_TIMEOUT(MEM_TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      int          nargs;
      int          ack_dly;   // -1: never acknowledge
      logic [31:0] rdata;
      logic [31:0] exp_reply;
      logic        exp_pause;
   } vec_t;

   vec_t vecs [9];
   int   errors = 0;
   int   checks = 0;
   int   tx_cnt = 0;
   int   wr_cyc = 0;
   logic both_seen = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe outputs on the falling edge, away from register updates.
   always @(negedge clk) begin
      if (bus.tx_start) tx_cnt++;
      if (bus.mem_wr) wr_cyc++;
      if (bus.mem_rd && bus.mem_wr) both_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      bus.rx_word  = w;
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      bus.rx_word  = 32'h0;
   endtask

   task automatic finish_tx();
      tick();
      chk("tx_start_oneshot", {31'd0, bus.tx_start}, 32'd0);
      bus.tx_busy = 1'b1;
      tick();
      tick();
      bus.tx_busy = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      int   n;
      int   tx0;
      logic is_rd;
      tx0   = tx_cnt;
      is_rd = (v.w0[31:24] == 8'h01);
      send_word(v.w0);
      if (v.nargs == 0) chk($sformatf("v%0d_pause", idx), {31'd0, bus.mcu_pause}, {31'd0, v.exp_pause});
      if (v.nargs >= 1) send_word(v.w1);
      if (v.nargs == 2) send_word(v.w2);
      if (v.nargs > 0) begin
         chk($sformatf("v%0d_mem_rd", idx), {31'd0, bus.mem_rd}, {31'd0, is_rd});
         chk($sformatf("v%0d_mem_wr", idx), {31'd0, bus.mem_wr}, {31'd0, !is_rd});
         chk($sformatf("v%0d_addr", idx), bus.mem_addr, v.w1);
         if (!is_rd) chk($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.w2);
         if (v.ack_dly >= 0) begin
            repeat (v.ack_dly) tick();
            bus.mem_rdata = v.rdata;
            bus.mem_ack   = 1'b1;
            tick();
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            chk($sformatf("v%0d_req_drop", idx), {31'd0, bus.mem_rd | bus.mem_wr}, 32'd0);
         end else begin
            n = 0;
            while ((bus.mem_rd || bus.mem_wr) && n < 200) begin
               tick();
               n++;
            end
            chk($sformatf("v%0d_mem_timeout_len", idx), n, MEM_TO);
         end
      end
      n = 0;
      while (!bus.tx_start && n < 50) begin
         tick();
         n++;
      end
      chk($sformatf("v%0d_tx_latency", idx), n, 1);
      chk($sformatf("v%0d_reply", idx), bus.tx_word, v.exp_reply);
      finish_tx();
      chk($sformatf("v%0d_tx_count", idx), tx_cnt - tx0, 1);
      chk($sformatf("v%0d_pause_end", idx), {31'd0, bus.mcu_pause}, {31'd0, v.exp_pause});
   endtask

   initial begin
      int   tx0;
      int   wr0;
      vec_t status0;
      vec_t pause1;

      vecs[0] = '{32'h0100_0000, 32'h0000_1000, 32'h0, 1, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{32'h0200_0000, 32'h0000_2004, 32'h1234_5678, 2, 2, 32'h5555_5555, 32'h0000_00AA, 1'b0};
      vecs[2] = '{32'h0300_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_00AA, 1'b1};
      vecs[3] = '{32'h0500_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_0001, 1'b1};
      vecs[4] = '{32'h04AB_CDEF, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_00AA, 1'b0};
      vecs[5] = '{32'h0500_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_0000, 1'b0};
      vecs[6] = '{32'h7F00_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'hFFFF_FFFE, 1'b0};
      vecs[7] = '{32'h0100_0000, 32'h0000_3000, 32'h0, 1, -1, 32'h0, 32'hFFFF_FFFD, 1'b0};
      vecs[8] = '{32'h0200_0000, 32'h0000_4008, 32'hCAFE_F00D, 2, -1, 32'h0, 32'hFFFF_FFFD, 1'b0};
      status0 = '{32'h0500_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_0000, 1'b0};
      pause1  = '{32'h0300_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_00AA, 1'b1};

      rst           = 1'b1;
      bus.rx_ready  = 1'b0;
      bus.rx_word   = 32'h0;
      bus.tx_busy   = 1'b0;
      bus.mem_rdata = 32'h0;
      bus.mem_ack   = 1'b0;
      #12;
      chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
      chk("rst_tx_word", bus.tx_word, 32'h0);
      chk("rst_mem_req", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_pause", {31'd0, bus.mcu_pause}, 32'd0);
      #1 rst = 1'b0;
      tick();
      tick();

      for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

      // WR frame stalls after the address; must be dropped with no access or reply.
      tx0 = tx_cnt;
      wr0 = wr_cyc;
      send_word(32'h0200_0000);
      send_word(32'h0000_5000);
      repeat (1100) tick();
      chk("argto_no_tx", tx_cnt - tx0, 0);
      chk("argto_no_wr", wr_cyc - wr0, 0);
      run_frame(status0, 100);

      // Transmitter busy while the reply is pending: tx_start must wait.
      tx0 = tx_cnt;
      bus.tx_busy = 1'b1;
      send_word(32'h0500_0000);
      repeat (5) tick();
      chk("busy_hold_tx_start", {31'd0, bus.tx_start}, 32'd0);
      chk("busy_hold_count", tx_cnt - tx0, 0);
      bus.tx_busy = 1'b0;
      tick();
      chk("busy_release_tx_start", {31'd0, bus.tx_start}, 32'd1);
      chk("busy_release_word", bus.tx_word, 32'h0);
      finish_tx();
      chk("busy_tx_count", tx_cnt - tx0, 1);

      // Reset asserted asynchronously in the middle of a write access.
      run_frame(pause1, 101);
      send_word(32'h0200_0000);
      send_word(32'h0000_6000);
      send_word(32'hA5A5_A5A5);
      chk("midwr_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midwr_rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      chk("midwr_rst_addr", bus.mem_addr, 32'h0);
      chk("midwr_rst_wdata", bus.mem_wdata, 32'h0);
      chk("midwr_rst_tx_word", bus.tx_word, 32'h0);
      chk("midwr_rst_pause", {31'd0, bus.mcu_pause}, 32'd0);
      #1 rst = 1'b0;
      tick();
      run_frame(status0, 102);

      chk("rd_wr_exclusive", {31'd0, both_seen}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
